// File: rtl/gaplus_vram_arbiter_if.sv
// Video/CPU/VRAM signal bundle for the Gaplus VRAM arbiter.
// CPU handshake: CPU_REQ is a level held with CPU_WE/CPU_A/CPU_DI stable until
// the requester samples the one-cycle CPU_ACK pulse, then drops (or re-raises
// with a new access); VID_STB and CPU_ACK are single-cycle strobes.
interface gaplus_vram_arbiter_if;
  logic        PH_SYNC;
  logic [10:0] VID_A;
  logic [15:0] VID_D;
  logic        VID_STB;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [11:0] CPU_A;
  logic [7:0]  CPU_DI;
  logic [7:0]  CPU_DO;
  logic        CPU_ACK;
  logic [10:0] RAM_A;
  logic        RAM_WE;
  logic [1:0]  RAM_BE;
  logic [15:0] RAM_DO;
  logic [15:0] RAM_DI;

  modport slave (
    input  PH_SYNC, VID_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, RAM_DI,
    output VID_D, VID_STB, CPU_DO, CPU_ACK, RAM_A, RAM_WE, RAM_BE, RAM_DO
  );

  modport master (
    output PH_SYNC, VID_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, RAM_DI,
    input  VID_D, VID_STB, CPU_DO, CPU_ACK, RAM_A, RAM_WE, RAM_BE, RAM_DO
  );
endinterface

// File: rtl/gaplus_vram_arbiter.sv
// Four-phase VRAM time-slot arbiter: phase 0 is the video fetch slot, phase 2
// the CPU slot; all VRAM-side outputs are registered one edge ahead of their phase.
module gaplus_vram_arbiter (
  input  logic                 VCLKx4,
  input  logic                 RESET,
  gaplus_vram_arbiter_if.slave vbus,
  output logic [1:0]           dbg_state,
  output logic [1:0]           dbg_phase
);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACC = 2'd2} state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [1:0]  phase_nx;
  logic        lat_we;
  logic [11:0] lat_a;
  logic [7:0]  lat_di;
  logic [10:0] vid_a_q;
  logic        accept;
  logic        present;
  logic        sel_we;
  logic [11:0] sel_a;
  logic [7:0]  sel_di;

  // RAM outputs are driven from the phase about to start, so a request being
  // latched this edge goes straight onto the bus in phase 2.
  always_comb begin
    phase_nx = vbus.PH_SYNC ? 2'd0 : phase + 2'd1;
    accept   = (state == IDLE) && (phase == 2'd1) && vbus.CPU_REQ;
    present  = (phase_nx == 2'd2) && (accept || (state == PEND));
    sel_we   = accept ? vbus.CPU_WE : lat_we;
    sel_a    = accept ? vbus.CPU_A  : lat_a;
    sel_di   = accept ? vbus.CPU_DI : lat_di;
  end

  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) begin
      phase        <= 2'd0;
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_a        <= '0;
      lat_di       <= '0;
      vid_a_q      <= '0;
      vbus.VID_D   <= '0;
      vbus.VID_STB <= 1'b0;
      vbus.CPU_DO  <= '0;
      vbus.CPU_ACK <= 1'b0;
      vbus.RAM_A   <= '0;
      vbus.RAM_WE  <= 1'b0;
      vbus.RAM_BE  <= 2'b00;
      vbus.RAM_DO  <= '0;
    end else begin
      phase        <= phase_nx;
      vbus.VID_STB <= (phase == 2'd1);
      vbus.CPU_ACK <= 1'b0;
      if (phase == 2'd1) vbus.VID_D <= vbus.RAM_DI;

      case (state)
        IDLE: begin
          if (accept) begin
            state  <= PEND;
            lat_we <= vbus.CPU_WE;
            lat_a  <= vbus.CPU_A;
            lat_di <= vbus.CPU_DI;
          end
        end
        PEND: begin
          if (!vbus.PH_SYNC && (phase == 2'd2)) state <= ACC;
        end
        ACC: begin
          // A phase resync mid-access throws the slot away; the latched request replays.
          if (vbus.PH_SYNC) begin
            state <= PEND;
          end else if (phase == 2'd3) begin
            state        <= IDLE;
            vbus.CPU_ACK <= 1'b1;
            if (!lat_we) vbus.CPU_DO <= lat_a[11] ? vbus.RAM_DI[15:8] : vbus.RAM_DI[7:0];
          end
        end
        default: state <= IDLE;
      endcase

      if (phase_nx == 2'd0) begin
        vbus.RAM_A  <= vbus.VID_A;
        vid_a_q     <= vbus.VID_A;
        vbus.RAM_WE <= 1'b0;
        vbus.RAM_BE <= 2'b00;
      end else if (present) begin
        vbus.RAM_A  <= sel_a[10:0];
        vbus.RAM_WE <= sel_we;
        vbus.RAM_BE <= sel_a[11] ? 2'b10 : 2'b01;
        vbus.RAM_DO <= {sel_di, sel_di};
      end else begin
        vbus.RAM_A  <= vid_a_q;
        vbus.RAM_WE <= 1'b0;
        vbus.RAM_BE <= 2'b00;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_phase = phase;
endmodule

// File: tb/tb_gaplus_vram_arbiter.sv
// Bench for gaplus_vram_arbiter: VRAM model, slot-level reference model with a
// per-cycle compare, and directed video/CPU/resync/reset scenarios.
module tb_gaplus_vram_arbiter;
  logic       VCLKx4 = 1'b0;
  logic       RESET  = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_phase;

  gaplus_vram_arbiter_if vbus();

  gaplus_vram_arbiter dut (
    .VCLKx4    (VCLKx4),
    .RESET     (RESET),
    .vbus      (vbus.slave),
    .dbg_state (dbg_state),
    .dbg_phase (dbg_phase)
  );

  // clock / reset
  always #20 VCLKx4 = ~VCLKx4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [15:0] mem [0:2047];
  logic [7:0]  exp_q[$];

  always @(posedge VCLKx4) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // VRAM: data valid one cycle after the address, byte-enabled writes
  always @(posedge VCLKx4) begin
    vbus.RAM_DI <= mem[vbus.RAM_A];
    if (vbus.RAM_WE) begin
      if (vbus.RAM_BE[1]) mem[vbus.RAM_A][15:8] <= vbus.RAM_DO[15:8];
      if (vbus.RAM_BE[0]) mem[vbus.RAM_A][7:0]  <= vbus.RAM_DO[7:0];
    end
  end

  // reference model: slot timetable plus one outstanding CPU job
  int          m_ph;
  bit          m_job_v, m_job_run, m_job_we;
  logic [11:0] m_job_a;
  logic [7:0]  m_job_di;
  logic [10:0] m_vid_addr;
  logic [15:0] e_vid_d;
  logic        e_vid_stb;
  logic [7:0]  e_cpu_do;
  logic        e_cpu_ack;
  logic [10:0] e_ram_a;
  logic        e_ram_we;
  logic [1:0]  e_ram_be;
  logic [15:0] e_ram_do;

  always @(posedge VCLKx4 or posedge RESET) begin : model
    int ph, nph;
    logic sync;
    logic [15:0] w;
    if (RESET) begin
      m_ph = 0; m_job_v = 0; m_job_run = 0; m_job_we = 0;
      m_job_a = '0; m_job_di = '0; m_vid_addr = '0;
      e_vid_d = '0; e_vid_stb = 0; e_cpu_do = '0; e_cpu_ack = 0;
      e_ram_a = '0; e_ram_we = 0; e_ram_be = '0; e_ram_do = '0;
    end else begin
      ph = m_ph;
      sync = vbus.PH_SYNC;
      e_cpu_ack = 0;
      e_vid_stb = (ph == 1);
      if (ph == 1) e_vid_d = mem[m_vid_addr];
      if (m_job_run) begin
        if (sync) m_job_run = 0;
        else if (ph == 3) begin
          e_cpu_ack = 1;
          w = mem[m_job_a[10:0]];
          if (!m_job_we) e_cpu_do = m_job_a[11] ? w[15:8] : w[7:0];
          m_job_v = 0;
          m_job_run = 0;
        end
      end else if (m_job_v && ph == 2 && !sync) begin
        m_job_run = 1;
      end
      if (!m_job_v && ph == 1 && vbus.CPU_REQ) begin
        m_job_v = 1; m_job_we = vbus.CPU_WE; m_job_a = vbus.CPU_A; m_job_di = vbus.CPU_DI;
      end
      nph = sync ? 0 : (ph + 1) % 4;
      m_ph = nph;
      if (nph == 0) begin
        e_ram_a = vbus.VID_A; m_vid_addr = vbus.VID_A; e_ram_we = 0; e_ram_be = 2'b00;
      end else if (nph == 2 && m_job_v) begin
        e_ram_a  = m_job_a[10:0];
        e_ram_we = m_job_we;
        e_ram_be = m_job_a[11] ? 2'b10 : 2'b01;
        e_ram_do = {m_job_di, m_job_di};
      end else begin
        e_ram_a = m_vid_addr; e_ram_we = 0; e_ram_be = 2'b00;
      end
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge VCLKx4) begin
    chk("vid_d",   vbus.VID_D,   e_vid_d);
    chk("vid_stb", vbus.VID_STB, e_vid_stb);
    chk("cpu_do",  vbus.CPU_DO,  e_cpu_do);
    chk("cpu_ack", vbus.CPU_ACK, e_cpu_ack);
    chk("ram_a",   vbus.RAM_A,   e_ram_a);
    chk("ram_we",  vbus.RAM_WE,  e_ram_we);
    chk("ram_be",  vbus.RAM_BE,  e_ram_be);
    if (e_ram_be != 2'b00 || RESET) chk("ram_do", vbus.RAM_DO, e_ram_do);
  end

  // driver tasks
  task automatic cpu_go(input logic we, input logic [11:0] a, input logic [7:0] di);
    @(negedge VCLKx4);
    vbus.CPU_WE = we; vbus.CPU_A = a; vbus.CPU_DI = di; vbus.CPU_REQ = 1'b1;
  endtask

  task automatic wait_ack(input bit drop, input bit is_read, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge VCLKx4);
      if (vbus.CPU_ACK) begin
        at = cyc;
        if (drop) vbus.CPU_REQ = 1'b0;
        if (is_read) chk("ack_cpu_do", vbus.CPU_DO, exp_q.pop_front());
        break;
      end
    end
    if (at < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_pend2(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge VCLKx4);
      if (m_ph == 2 && m_job_v && !m_job_run) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("pend2_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vid_d"},   vbus.VID_D,   0);
    chk({tag, "_vid_stb"}, vbus.VID_STB, 0);
    chk({tag, "_cpu_do"},  vbus.CPU_DO,  0);
    chk({tag, "_cpu_ack"}, vbus.CPU_ACK, 0);
    chk({tag, "_ram_a"},   vbus.RAM_A,   0);
    chk({tag, "_ram_we"},  vbus.RAM_WE,  0);
    chk({tag, "_ram_be"},  vbus.RAM_BE,  0);
    chk({tag, "_ram_do"},  vbus.RAM_DO,  0);
    chk({tag, "_phase"},   dbg_phase,    0);
  endtask

  initial begin
    int c, a0, a1, last, nstb, nwe, nack;
    logic [11:0] b2b_a [4];
    logic [7:0]  b2b_d [4];
    b2b_a = '{12'h010, 12'h810, 12'h123, 12'h805};
    b2b_d = '{8'hAB, 8'h12, 8'hEF, 8'h5A};
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h123] = 16'hBEEF;
    mem[11'h010] = 16'h12AB;
    vbus.PH_SYNC = 0; vbus.VID_A = 11'h123;
    vbus.CPU_REQ = 0; vbus.CPU_WE = 0; vbus.CPU_A = '0; vbus.CPU_DI = '0;

    // reset state
    RESET = 1'b1;
    repeat (3) @(negedge VCLKx4);
    chk_all_zero("reset");
    RESET = 1'b0;
    @(negedge VCLKx4);
    chk("first_ph1_stb", vbus.VID_STB, 0);
    @(negedge VCLKx4);
    chk("first_ph2_stb", vbus.VID_STB, 1);
    chk("first_ph2_phase", dbg_phase, 2);

    // video only
    last = cyc; nstb = 0;
    repeat (16) begin
      @(negedge VCLKx4);
      chk("video_no_we", vbus.RAM_WE, 0);
      if (vbus.VID_STB) begin
        chk("video_d", vbus.VID_D, 16'hBEEF);
        chk("video_gap", cyc - last, 4);
        last = cyc; nstb++;
      end
    end
    chk("video_stb_count", nstb, 4);

    // CPU write, high byte; later input changes must be ignored
    cpu_go(1'b1, 12'h805, 8'h5A);
    wait_pend2(c);
    chk("wr_ram_a",  vbus.RAM_A,  11'h005);
    chk("wr_ram_be", vbus.RAM_BE, 2'b10);
    chk("wr_ram_do", vbus.RAM_DO, 16'h5A5A);
    chk("wr_ram_we", vbus.RAM_WE, 1);
    vbus.CPU_A = 12'h3FF; vbus.CPU_DI = 8'hC3; vbus.CPU_WE = 1'b0;
    wait_ack(1, 0, a0);
    chk("wr_ack_latency", a0 - c, 2);
    chk("wr_mem", mem[11'h005], 16'h5A00);

    // CPU reads, low then high byte
    cpu_go(1'b0, 12'h010, 8'h00);
    exp_q.push_back(8'hAB);
    wait_ack(1, 1, a0);
    @(negedge VCLKx4);
    chk("rd_ack_single", vbus.CPU_ACK, 0);
    cpu_go(1'b0, 12'h810, 8'h00);
    exp_q.push_back(8'h12);
    wait_ack(1, 1, a0);

    // back-to-back, request held across ACKs
    cpu_go(1'b0, b2b_a[0], 8'h00);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(b2b_d[k]);
      wait_ack(k == 3, 1, a1);
      if (k > 0) chk("b2b_ack_gap", a1 - a0, 4);
      a0 = a1;
      if (k < 3) vbus.CPU_A = b2b_a[k+1];
    end

    // phase resync during the ACC cycle of a write
    cpu_go(1'b1, 12'h020, 8'h77);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge VCLKx4);
      if (m_job_run && m_ph == 3) begin c = cyc; break; end
    end
    if (c < 0) chk("acc_timeout", 0, 1);
    vbus.PH_SYNC = 1'b1;
    @(negedge VCLKx4);
    vbus.PH_SYNC = 1'b0;
    chk("abort_no_ack", vbus.CPU_ACK, 0);
    chk("abort_phase0", dbg_phase, 0);
    wait_pend2(c);
    chk("redo_ram_we", vbus.RAM_WE, 1);
    chk("redo_ram_a",  vbus.RAM_A,  11'h020);
    chk("redo_ram_be", vbus.RAM_BE, 2'b01);
    chk("redo_ram_do", vbus.RAM_DO, 16'h7777);
    wait_ack(1, 0, a0);
    chk("redo_ack_latency", a0 - c, 2);
    nack = 0;
    repeat (8) begin
      @(negedge VCLKx4);
      if (vbus.CPU_ACK) nack++;
    end
    chk("redo_single_ack", nack, 0);
    chk("redo_mem", mem[11'h020], 16'h0077);

    // asynchronous reset while a write is presented
    cpu_go(1'b1, 12'h030, 8'h99);
    wait_pend2(c);
    chk("pend_ram_we", vbus.RAM_WE, 1);
    #2;
    RESET = 1'b1;
    vbus.CPU_REQ = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge VCLKx4);
    RESET = 1'b0;
    nwe = 0; nack = 0;
    repeat (16) begin
      @(negedge VCLKx4);
      if (vbus.RAM_WE) nwe++;
      if (vbus.CPU_ACK) nack++;
    end
    chk("post_rst_no_we", nwe, 0);
    chk("post_rst_no_ack", nack, 0);
    chk("post_rst_mem", mem[11'h030], 16'h0000);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
